uart_packet_sender: RTL and testbench

Serialises a fixed-length multi-byte packet onto a single UART TX line in 8N1 format. On a one-cycle enable pulse it snapshots the whole packet and transmits it byte by byte, most-significant byte first. It sits between packet-producing logic (e.g. FFT result buffers) and the FTDI TX pin. Framing is compatible with the team's 8N1 receiver at the same bit period.

---
 rtl/uart_packet_sender_pkg.sv | 21 ++
 rtl/uart_packet_sender.sv | 156 +++++++++++++++
 tb/tb_uart_packet_sender.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_packet_sender_pkg.sv
// uart_packet_sender_pkg
// Shared UART framing constants and the transmitter FSM state type.
// Imported by uart_packet_sender and its testbench.
`timescale 1ns/1ps

package uart_packet_sender_pkg;

    // 8N1 line levels and frame geometry
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam int   DATA_BITS  = 8;
    localparam int   FRAME_BITS = 10;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

endpackage

// File: rtl/uart_packet_sender.sv
// uart_packet_sender
// Serialises a PACKET_SIZE-byte packet onto an 8N1 UART line, most
// significant byte first, each byte LSB first. A one-cycle enable in IDLE
// snapshots the packet and starts the start bit on the same clock edge.
//
// Ports:
//   clk     - system clock, all logic on rising edge
//   rst_n   - asynchronous active-low reset
//   packet  - packet data, byte 0 (sent first) in the top 8 bits
//   enable  - start request, ignored while a packet is in flight
//   txd     - registered UART TX line, idle high
//   busy    - high for exactly PACKET_SIZE*10*CLKS_PER_BIT cycles per packet
`timescale 1ns/1ps

module uart_packet_sender
    import uart_packet_sender_pkg::*;
#(
    parameter int PACKET_SIZE  = 16'd15,
    parameter int CLKS_PER_BIT = 104
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [8*PACKET_SIZE-1:0] packet,
    input  logic                     enable,
    output logic                     txd,
    output logic                     busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (PACKET_SIZE > 0) ? $clog2(PACKET_SIZE + 1) : 1;

    localparam logic [CW-1:0] LAST_CLK  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BYTE = BW'(PACKET_SIZE - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

    tx_state_t state;
    tx_state_t next_state;

    logic [CW-1:0]              clk_cnt;
    logic [2:0]                 bit_idx;
    logic [BW-1:0]              byte_idx;
    logic [8*PACKET_SIZE-1:0]   shreg;

    logic [7:0] cur_byte;
    logic       period_done;
    logic [2:0] next_bit_idx;
    logic       txd_d;
    logic       busy_d;

    // The byte on the wire is always the top byte of the snapshot; the
    // snapshot shifts up by one byte at the end of each stop bit.
    assign cur_byte    = shreg[8*PACKET_SIZE-1 -: 8];
    assign period_done = (clk_cnt == LAST_CLK);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (enable) next_state = START;
            START: if (period_done) next_state = DATA;
            DATA:  if (period_done && (bit_idx == LAST_BIT)) next_state = STOP;
            STOP: begin
                if (period_done) begin
                    next_state = (byte_idx == LAST_BYTE) ? IDLE : START;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Output logic: computes the line level for the coming cycle so that
    // txd and busy can be registered yet still change on the same edge as
    // the state (start bit visible from the edge that samples enable).
    always_comb begin
        next_bit_idx = bit_idx;
        if ((state == DATA) && period_done) begin
            next_bit_idx = bit_idx + 3'd1;
        end

        txd_d  = STOP_BIT;
        busy_d = 1'b1;
        case (next_state)
            IDLE: begin
                txd_d  = STOP_BIT;
                busy_d = 1'b0;
            end
            START:   txd_d = START_BIT;
            DATA:    txd_d = cur_byte[next_bit_idx];
            STOP:    txd_d = STOP_BIT;
            default: begin
                txd_d  = STOP_BIT;
                busy_d = 1'b0;
            end
        endcase
    end

    // Datapath: bit-period counter, bit/byte indices, packet snapshot and
    // the registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_cnt  <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            shreg    <= '0;
            txd      <= STOP_BIT;
            busy     <= 1'b0;
        end else begin
            txd  <= txd_d;
            busy <= busy_d;
            case (state)
                IDLE: begin
                    if (enable) begin
                        shreg    <= packet;
                        clk_cnt  <= '0;
                        bit_idx  <= '0;
                        byte_idx <= '0;
                    end
                end
                START: begin
                    clk_cnt <= period_done ? '0 : clk_cnt + 1'b1;
                end
                DATA: begin
                    clk_cnt <= period_done ? '0 : clk_cnt + 1'b1;
                    if (period_done) begin
                        bit_idx <= bit_idx + 3'd1;
                    end
                end
                STOP: begin
                    clk_cnt <= period_done ? '0 : clk_cnt + 1'b1;
                    if (period_done) begin
                        bit_idx <= '0;
                        // Index saturates on the last byte; it is cleared
                        // again when the next packet is latched.
                        if (byte_idx != LAST_BYTE) begin
                            byte_idx <= byte_idx + 1'b1;
                            shreg    <= shreg << 8;
                        end
                    end
                end
                default: begin
                    clk_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_packet_sender.sv
`timescale 1ns/1ps

module tb_uart_packet_sender;
    import uart_packet_sender_pkg::*;

    localparam int PS         = 15;
    localparam int C          = 4;
    localparam int PKT_CYCLES = PS * FRAME_BITS * C;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic [8*PS-1:0]   packet;
    logic              txd;
    logic              busy;

    int          checks     = 0;
    int          errors     = 0;
    int          rxFrames   = 0;
    int          resetEpoch = 0;
    logic [7:0]  expQ[$];

    always #5 clk = ~clk;

    uart_packet_sender #(
        .PACKET_SIZE (PS),
        .CLKS_PER_BIT(C)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .packet(packet),
        .enable(enable),
        .txd   (txd),
        .busy  (busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Called at a negedge: drives the packet and a one-cycle enable, queues
    // the bytes the receiver should see, returns at the negedge after the
    // edge that sampled enable.
    task automatic applyStimulus(input logic [8*PS-1:0] pkt);
        packet = pkt;
        for (int i = 0; i < PS; i++) expQ.push_back(pkt[(PS-1-i)*8 +: 8]);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic measureBusy(output int cycles);
        cycles = 0;
        while (busy === 1'b1 && cycles < 2*PKT_CYCLES) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    // Loopback 8N1 receiver: samples mid-bit and scores against the queue.
    // Frames that straddle a reset are discarded.
    initial begin : rx
        logic [7:0] b;
        logic       startBit;
        logic       stopBit;
        int         epoch;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && txd === 1'b0) begin
                epoch = resetEpoch;
                repeat (C/2) @(negedge clk);
                startBit = txd;
                for (int i = 0; i < 8; i++) begin
                    repeat (C) @(negedge clk);
                    b[i] = txd;
                end
                repeat (C) @(negedge clk);
                stopBit = txd;
                if (epoch == resetEpoch) begin
                    checkOutput("rxStartBit", 32'(startBit), 32'd0);
                    checkOutput("rxStopBit", 32'(stopBit), 32'd1);
                    checkOutput("rxQueueNonEmpty", 32'(expQ.size() > 0), 32'd1);
                    if (expQ.size() > 0) checkOutput("rxByte", 32'(b), 32'(expQ.pop_front()));
                    rxFrames++;
                end
            end
        end
    end

    initial begin : stimulus
        logic [8*PS-1:0]     msg;
        logic [8*PS-1:0]     msg2;
        logic [8*PS-1:0]     msg3;
        logic                trace[FRAME_BITS*C];
        logic [FRAME_BITS-1:0] expFrame;
        logic                sawActivity;
        int                  cnt;
        int                  gap;
        int                  framesBefore;

        msg      = "this is a test ";
        msg2     = "abort-me-please";
        msg3     = "0123456789ABCDE";
        expFrame = {STOP_BIT, 8'h74, START_BIT};

        // Reset state and idle line
        rst_n  = 1'b0;
        enable = 1'b0;
        packet = '0;
        repeat (3) @(negedge clk);
        checkOutput("resetTxd", 32'(txd), 32'd1);
        checkOutput("resetBusy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        sawActivity = 1'b0;
        repeat (1000) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0) sawActivity = 1'b1;
        end
        checkOutput("idleQuiet", 32'(sawActivity), 32'd0);

        // Single packet, enable pulses while busy, packet overwritten after latch
        framesBefore = rxFrames;
        applyStimulus(msg);
        checkOutput("busyRise", 32'(busy), 32'd1);
        checkOutput("startBitImmediate", 32'(txd), 32'd0);
        cnt = 0;
        while (busy === 1'b1 && cnt < 2*PKT_CYCLES) begin
            if (cnt < FRAME_BITS*C) trace[cnt] = txd;
            if (cnt == 1) packet = '1;
            enable = (cnt == 50 || cnt == 300);
            cnt++;
            @(negedge clk);
        end
        enable = 1'b0;
        checkOutput("busyLength", 32'(cnt), 32'(PKT_CYCLES));
        for (int j = 0; j < FRAME_BITS; j++) begin
            checkOutput($sformatf("firstFrameBit%0d", j), 32'(trace[j*C + C/2]), 32'(expFrame[j]));
        end
        sawActivity = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (busy !== 1'b0) sawActivity = 1'b1;
        end
        checkOutput("noRestartAfterPulses", 32'(sawActivity), 32'd0);
        checkOutput("rxFrameCount1", 32'(rxFrames - framesBefore), 32'(PS));
        checkOutput("rxQueueDrained1", 32'(expQ.size()), 32'd0);

        // Reset 200 cycles into a transfer, then a clean packet
        applyStimulus(msg2);
        repeat (199) @(negedge clk);
        rst_n = 1'b0;
        resetEpoch++;
        expQ.delete();
        #1;
        checkOutput("asyncResetTxd", 32'(txd), 32'd1);
        checkOutput("asyncResetBusy", 32'(busy), 32'd0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        checkOutput("postResetTxd", 32'(txd), 32'd1);
        checkOutput("postResetBusy", 32'(busy), 32'd0);
        framesBefore = rxFrames;
        applyStimulus(msg);
        measureBusy(cnt);
        checkOutput("busyLengthAfterReset", 32'(cnt), 32'(PKT_CYCLES));
        repeat (10) @(negedge clk);
        checkOutput("rxFrameCount2", 32'(rxFrames - framesBefore), 32'(PS));
        checkOutput("rxQueueDrained2", 32'(expQ.size()), 32'd0);

        // Enable held high: two back-to-back packets, one idle cycle between
        packet = msg3;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < PS; i++) expQ.push_back(msg3[(PS-1-i)*8 +: 8]);
        end
        framesBefore = rxFrames;
        enable = 1'b1;
        @(negedge clk);
        checkOutput("heldBusyRise", 32'(busy), 32'd1);
        measureBusy(cnt);
        checkOutput("heldBusyLength1", 32'(cnt), 32'(PKT_CYCLES));
        gap = 0;
        while (busy === 1'b0 && gap < 10) begin
            gap++;
            @(negedge clk);
        end
        checkOutput("heldIdleGap", 32'(gap), 32'd1);
        measureBusy(cnt);
        enable = 1'b0;
        checkOutput("heldBusyLength2", 32'(cnt), 32'(PKT_CYCLES));
        sawActivity = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (busy !== 1'b0 || txd !== 1'b1) sawActivity = 1'b1;
        end
        checkOutput("heldTailQuiet", 32'(sawActivity), 32'd0);
        checkOutput("rxFrameCount3", 32'(rxFrames - framesBefore), 32'(2*PS));
        checkOutput("rxQueueDrained3", 32'(expQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
